// File: rtl/aging_round_robin_arbiter.sv
// aging_round_robin_arbiter: round-robin issue arbiter with a critical class, burst limit and optional aging.
// Define AGING_ROUND_ROBIN_ARBITER_AGING_EN to promote long-waiting requesters into the critical class.
module aging_round_robin_arbiter #(
    parameter int SINGLE_REQUEST_WIDTH_IN_BITS = 64,
    parameter int NUM_REQUEST = 4,
    parameter int AGE_THRESHOLD = 15,
    parameter int CRITICAL_BURST_LIMIT = 4,
    parameter int NUM_REQUEST_LOG2 = $clog2(NUM_REQUEST)
) (
    input  logic                                                clk_in,
    input  logic                                                reset_in,
    input  logic [SINGLE_REQUEST_WIDTH_IN_BITS*NUM_REQUEST-1:0] request_flatted_in,
    input  logic [NUM_REQUEST-1:0]                              request_valid_flatted_in,
    input  logic [NUM_REQUEST-1:0]                              request_critical_flatted_in,
    output logic [NUM_REQUEST-1:0]                              issue_ack_out,
    output logic [SINGLE_REQUEST_WIDTH_IN_BITS-1:0]             request_out,
    output logic                                                request_valid_out,
    output logic [NUM_REQUEST_LOG2-1:0]                         grant_index_out,
    input  logic                                                issue_ack_in
);
    localparam int W = SINGLE_REQUEST_WIDTH_IN_BITS;
    localparam int BW = $clog2(CRITICAL_BURST_LIMIT + 1);

    if (NUM_REQUEST < 2 || AGE_THRESHOLD < 1 || CRITICAL_BURST_LIMIT < 1) begin : g_bad_params
        $error("aging_round_robin_arbiter: parameter out of range");
    end

    logic [W-1:0]                payload [NUM_REQUEST];
    logic [NUM_REQUEST-1:0]      eff_crit, non_crit, cand;
    logic [NUM_REQUEST_LOG2-1:0] last_grant_index, winner;
    logic [BW-1:0]               burst_cnt;
    logic                        load, any_valid, grant;

    // First set bit of mask, scanning upward from last+1 with wrap-around.
    function automatic logic [NUM_REQUEST_LOG2-1:0] rr_first(
        input logic [NUM_REQUEST-1:0]      mask,
        input logic [NUM_REQUEST_LOG2-1:0] last
    );
        logic [NUM_REQUEST_LOG2-1:0] i;
        rr_first = last;
        for (int k = NUM_REQUEST; k >= 1; k--) begin
            i = NUM_REQUEST_LOG2'((int'(last) + k) % NUM_REQUEST);
            if (mask[i]) rr_first = i;
        end
    endfunction

`ifdef AGING_ROUND_ROBIN_ARBITER_AGING_EN
    localparam int AW = $clog2(AGE_THRESHOLD + 1);
    logic [AW-1:0] age [NUM_REQUEST];

    always_ff @(posedge clk_in) begin
        for (int i = 0; i < NUM_REQUEST; i++)
            age[i] <= (reset_in || !request_valid_flatted_in[i] || issue_ack_out[i]) ? '0 :
                      (age[i] == AW'(AGE_THRESHOLD)) ? age[i] : age[i] + AW'(1);
    end

    always_comb begin
        for (int i = 0; i < NUM_REQUEST; i++)
            eff_crit[i] = request_valid_flatted_in[i] &
                          (request_critical_flatted_in[i] | (age[i] == AW'(AGE_THRESHOLD)));
    end
`else
    assign eff_crit = request_valid_flatted_in & request_critical_flatted_in;
`endif

    always_comb begin
        for (int i = 0; i < NUM_REQUEST; i++) payload[i] = request_flatted_in[i*W +: W];
        load = ~request_valid_out | issue_ack_in;
        any_valid = |request_valid_flatted_in;
        non_crit = request_valid_flatted_in & ~eff_crit;
        cand = (|eff_crit && burst_cnt < BW'(CRITICAL_BURST_LIMIT)) ? eff_crit :
               (|non_crit) ? non_crit : request_valid_flatted_in;
        winner = rr_first(cand, last_grant_index);
        grant = load & any_valid & ~reset_in;
        issue_ack_out = grant ? NUM_REQUEST'(1) << winner : '0;
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            request_out <= '0;
            request_valid_out <= 1'b0;
            grant_index_out <= '0;
            last_grant_index <= NUM_REQUEST_LOG2'(NUM_REQUEST - 1);
            burst_cnt <= '0;
        end else if (load) begin
            request_valid_out <= any_valid;
            request_out <= any_valid ? payload[winner] : '0;
            if (any_valid) begin
                grant_index_out <= winner;
                last_grant_index <= winner;
                burst_cnt <= !eff_crit[winner] ? '0 :
                             (burst_cnt == BW'(CRITICAL_BURST_LIMIT)) ? burst_cnt : burst_cnt + BW'(1);
            end
        end
    end
endmodule

// File: tb/tb_aging_round_robin_arbiter.sv
// tb_aging_round_robin_arbiter: directed stimulus with a per-cycle reference model and literal grant checks.
module tb_aging_round_robin_arbiter;
    localparam int N = 4;
    localparam int W = 8;
    localparam int TH = 3;
    localparam int LIM = 2;

    logic           clk_in = 1'b0;
    logic           reset_in = 1'b1;
    logic [N*W-1:0] request_flatted_in = 32'hA3A2A1A0;
    logic [N-1:0]   request_valid_flatted_in = '0;
    logic [N-1:0]   request_critical_flatted_in = '0;
    logic [N-1:0]   issue_ack_out;
    logic [W-1:0]   request_out;
    logic           request_valid_out;
    logic [1:0]     grant_index_out;
    logic           issue_ack_in = 1'b1;

    int checks = 0;
    int errors = 0;

    aging_round_robin_arbiter #(
        .SINGLE_REQUEST_WIDTH_IN_BITS(W),
        .NUM_REQUEST(N),
        .AGE_THRESHOLD(TH),
        .CRITICAL_BURST_LIMIT(LIM)
    ) dut (
        .clk_in(clk_in),
        .reset_in(reset_in),
        .request_flatted_in(request_flatted_in),
        .request_valid_flatted_in(request_valid_flatted_in),
        .request_critical_flatted_in(request_critical_flatted_in),
        .issue_ack_out(issue_ack_out),
        .request_out(request_out),
        .request_valid_out(request_valid_out),
        .grant_index_out(grant_index_out),
        .issue_ack_in(issue_ack_in)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: slot contents, last winner, burst length and per-requester wait times.
    bit       m_init = 1'b0;
    bit       m_valid = 1'b0;
    int       m_idx = 0;
    int       m_last = N - 1;
    int       m_burst = 0;
    int       m_age [N];
    logic [W-1:0] m_data = '0;

    function automatic int rr_pick(input logic [N-1:0] mask, input int last);
        for (int k = 1; k <= N; k++)
            if (mask[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    always @(negedge clk_in) begin
        logic [N-1:0] eff, nc, exp_ack;
        logic         ld, aged;
        int           w;
        ld = !m_valid || issue_ack_in;
        for (int i = 0; i < N; i++) begin
`ifdef AGING_ROUND_ROBIN_ARBITER_AGING_EN
            aged = (m_age[i] >= TH);
`else
            aged = 1'b0;
`endif
            eff[i] = request_valid_flatted_in[i] && (request_critical_flatted_in[i] || aged);
        end
        nc = request_valid_flatted_in & ~eff;
        if (eff != 0 && m_burst < LIM) w = rr_pick(eff, m_last);
        else if (nc != 0) w = rr_pick(nc, m_last);
        else w = rr_pick(request_valid_flatted_in, m_last);
        exp_ack = '0;
        if (ld && !reset_in && w >= 0) exp_ack[w] = 1'b1;
        if (m_init) begin
            check("model_ack", issue_ack_out, exp_ack);
            check("model_valid", request_valid_out, m_valid);
            check("model_data", request_out, m_data);
            check("model_index", grant_index_out, m_idx);
        end
        if (reset_in) begin
            m_init = 1'b1;
            m_valid = 1'b0;
            m_data = '0;
            m_idx = 0;
            m_last = N - 1;
            m_burst = 0;
            for (int i = 0; i < N; i++) m_age[i] = 0;
        end else begin
            for (int i = 0; i < N; i++)
                m_age[i] = (!request_valid_flatted_in[i] || exp_ack[i]) ? 0 :
                           (m_age[i] < TH ? m_age[i] + 1 : TH);
            if (ld) begin
                m_valid = (w >= 0);
                m_data = (w >= 0) ? request_flatted_in[w*W +: W] : '0;
                if (w >= 0) begin
                    m_idx = w;
                    m_last = w;
                    m_burst = eff[w] ? (m_burst < LIM ? m_burst + 1 : LIM) : 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        reset_in = 1'b1;
        request_valid_flatted_in = '0;
        request_critical_flatted_in = '0;
        issue_ack_in = 1'b1;
        tick();
        reset_in = 1'b0;
    endtask

    task automatic expect_grant(input string name, input int idx);
        tick();
        check({name, "_valid"}, request_valid_out, 1'b1);
        check({name, "_index"}, grant_index_out, idx);
        check({name, "_data"}, request_out, 8'hA0 + idx);
    endtask

    initial begin
        int seq1 [5] = '{0, 1, 2, 3, 0};
        int seq3 [6] = '{0, 1, 3, 0, 1, 3};
        tick();
        request_valid_flatted_in = 4'b1111;
        #1 check("reset_ack", issue_ack_out, 4'b0000);
        check("reset_valid", request_valid_out, 1'b0);
        check("reset_data", request_out, 8'h00);
        check("reset_index", grant_index_out, 2'd0);
        tick();
        reset_in = 1'b0;
        #1 check("first_ack", issue_ack_out, 4'b0001);
        check("latency_valid", request_valid_out, 1'b0);
        foreach (seq1[i]) expect_grant("rr", seq1[i]);

        do_reset();
        request_valid_flatted_in = 4'b0111;
        request_critical_flatted_in = 4'b0100;
        expect_grant("crit_first", 2);
        request_valid_flatted_in = 4'b0011;
        request_critical_flatted_in = 4'b0000;
        expect_grant("crit_then0", 0);
        expect_grant("crit_then1", 1);

        do_reset();
        request_valid_flatted_in = 4'b1011;
        request_critical_flatted_in = 4'b0011;
        foreach (seq3[i]) expect_grant("burst", seq3[i]);

        do_reset();
        request_valid_flatted_in = 4'b0010;
        expect_grant("hold_load", 1);
        request_valid_flatted_in = 4'b0001;
        issue_ack_in = 1'b0;
        repeat (5) begin
            #1 check("hold_ack", issue_ack_out, 4'b0000);
            tick();
            check("hold_valid", request_valid_out, 1'b1);
            check("hold_data", request_out, 8'hA1);
            check("hold_index", grant_index_out, 2'd1);
        end
        issue_ack_in = 1'b1;
        #1 check("ack_return", issue_ack_out, 4'b0001);
        expect_grant("after_hold", 0);

        do_reset();
        request_valid_flatted_in = 4'b1010;
        expect_grant("age_first", 1);
        request_valid_flatted_in = 4'b1000;
        issue_ack_in = 1'b0;
        repeat (3) tick();
        request_valid_flatted_in = 4'b1100;
        issue_ack_in = 1'b1;
`ifdef AGING_ROUND_ROBIN_ARBITER_AGING_EN
        #1 check("aged_ack", issue_ack_out, 4'b1000);
        expect_grant("aged_win", 3);
`else
        #1 check("rr_ack", issue_ack_out, 4'b0100);
        expect_grant("rr_win", 2);
`endif

        reset_in = 1'b1;
        request_valid_flatted_in = 4'b1111;
        #1 check("midreset_ack", issue_ack_out, 4'b0000);
        tick();
        check("midreset_valid", request_valid_out, 1'b0);
        check("midreset_data", request_out, 8'h00);
        check("midreset_index", grant_index_out, 2'd0);
        reset_in = 1'b0;
        #1 check("restart_ack", issue_ack_out, 4'b0001);
        expect_grant("restart", 0);

        request_valid_flatted_in = 4'b0000;
        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
